fact_pow_engine: RTL



---
 rtl/fact_pow_pkg.sv | 15 +
 rtl/fact_pow_engine_mul.sv | 46 ++++
 rtl/fact_pow_engine.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fact_pow_pkg.sv
// Shared types and constants for the factorial / power engine.
package fact_pow_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    MUL  = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } stateT;

  localparam logic MODE_FACT = 1'b0;
  localparam logic MODE_POW  = 1'b1;

endpackage

// File: rtl/fact_pow_engine_mul.sv
// Sequential shift-add multiplier: go loads the operands and retires bit 0,
// the remaining WIDTH-1 bits follow one per cycle; valid pulses WIDTH cycles after go.
module shift_add_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 valid
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    steps;

  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      steps   <= '0;
      valid   <= 1'b0;
    end else if (go) begin
      product <= b[0] ? PW'(a) : '0;
      mcand   <= PW'(a) << 1;
      mplier  <= b >> 1;
      steps   <= CW'(WIDTH - 1);
      valid   <= 1'b0;
    end else if (steps != '0) begin
      product <= product + (mplier[0] ? mcand : '0);
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      steps   <= steps - CW'(1);
      valid   <= (steps == CW'(1));
    end else begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fact_pow_engine.sv
// Multi-cycle engine computing op_a! or op_a^op_b modulo 2^WIDTH with sticky overflow.
// Build option FACT_POW_EARLY_ABORT_EN: stop at the first overflowing step.
module fact_pow_engine
  import fact_pow_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  stateT state, stateNext;

  logic                 modeQ;
  logic [WIDTH-1:0]     opAQ, opBQ;
  logic [WIDTH-1:0]     acc;
  logic [CNT_WIDTH-1:0] cnt;

  logic                 mulGo;
  logic [WIDTH-1:0]     mulA, mulB;
  logic [2*WIDTH-1:0]   product;
  logic                 mulValid;
  logic                 busyNext, doneNext;

  logic stepOvf_c, loopEnd_c, trivial_c, abort_c;

  assign stepOvf_c = |product[2*WIDTH-1:WIDTH];
  assign loopEnd_c = (modeQ == MODE_FACT) ? (cnt <= CNT_WIDTH'(2)) : (cnt == CNT_WIDTH'(1));
  assign trivial_c = (modeQ == MODE_FACT) ? (opAQ <= WIDTH'(1)) : (opBQ == '0);

`ifdef FACT_POW_EARLY_ABORT_EN
  assign abort_c = stepOvf_c;
`else
  assign abort_c = 1'b0;
`endif

  shift_add_mul #(.WIDTH(WIDTH)) uMul (
    .clk     (clk),
    .reset   (reset),
    .go      (mulGo),
    .a       (mulA),
    .b       (mulB),
    .product (product),
    .valid   (mulValid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = INIT;
      INIT:    stateNext = trivial_c ? DONE : MUL;
      MUL:     if (mulValid) stateNext = STEP;
      STEP:    stateNext = (loopEnd_c || abort_c) ? DONE : MUL;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // In INIT the accumulator is 1 and both modes multiply by op_a first.
  always_comb begin
    mulGo    = 1'b0;
    mulA     = product[WIDTH-1:0];
    mulB     = opAQ;
    busyNext = (stateNext == INIT) || (stateNext == MUL) || (stateNext == STEP);
    doneNext = (stateNext == DONE);
    case (state)
      INIT: begin
        mulGo = !trivial_c;
        mulA  = WIDTH'(1);
      end
      STEP: begin
        mulGo = (stateNext == MUL);
        if (modeQ == MODE_FACT) mulB = WIDTH'(cnt - CNT_WIDTH'(1));
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, accumulator, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      modeQ    <= MODE_FACT;
      opAQ     <= '0;
      opBQ     <= '0;
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= busyNext;
      done <= doneNext;
      case (state)
        IDLE: if (start) begin
          modeQ <= mode;
          opAQ  <= op_a;
          opBQ  <= op_b;
        end
        INIT: begin
          acc      <= WIDTH'(1);
          overflow <= 1'b0;
          cnt      <= (modeQ == MODE_FACT) ? CNT_WIDTH'(opAQ) : CNT_WIDTH'(opBQ);
          if (trivial_c) result <= WIDTH'(1);
        end
        STEP: begin
          acc      <= product[WIDTH-1:0];
          overflow <= overflow | stepOvf_c;
          cnt      <= cnt - CNT_WIDTH'(1);
          if (stateNext == DONE) result <= product[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
